// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared limits and counter-width helper for the synchroniser bank
package sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILT_MAX   = 255;

  // Counter must hold 0..FILT_CYC-1; keep at least one bit so bypass builds stay legal.
  function automatic int cnt_width(input int filt_cyc);
    int w;
    w = $clog2(filt_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_chan.sv
// rtl/sync_chan.sv - one channel: synchroniser chain, debounce filter, edge pulses
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_CYC = 3,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(FILT_CYC);
  // With FILT_CYC of 0 or 1 the counter never leaves 0, so a mismatch is taken at once.
  localparam logic [CW-1:0] CNT_LAST = CW'((FILT_CYC == 0) ? 0 : FILT_CYC - 1);

  logic [STAGES-1:0] r_chain;
  logic              r_sync;
  logic              r_rise;
  logic              r_fall;
  logic [CW-1:0]     r_cnt;

  logic              w_raw;
  logic              w_take;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_raw = r_chain[STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chain <= {STAGES{RST_BIT}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], async_i};
    end
  end

  always_comb begin
    w_take    = 1'b0;
    w_cnt_nxt = '0;
    if (w_raw != r_sync) begin
      if (r_cnt == CNT_LAST) begin
        w_take = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= RST_BIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_rise <= w_take & w_raw;
      r_fall <= w_take & ~w_raw;
      if (w_take) begin
        r_sync <= w_raw;
      end
    end
  end

  assign sync_o = r_sync;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - bank of independent synchronised, debounced level inputs
module sync_debounce_bank
  import sync_pkg::*;
#(
  parameter int            CH       = 4,
  parameter int            STAGES   = 2,
  parameter int            FILT_CYC = 3,
  parameter logic [CH-1:0] RST_VAL  = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CH-1:0] async_sig_i,
  output logic [CH-1:0] sync_sig_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("sync_debounce_bank: CH=%0d outside 1..32", CH);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_debounce_bank: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end
  if (FILT_CYC < 0 || FILT_CYC > FILT_MAX) begin : g_bad_filt
    $error("sync_debounce_bank: FILT_CYC=%0d outside 0..%0d", FILT_CYC, FILT_MAX);
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    sync_chan #(
      .STAGES  (STAGES),
      .FILT_CYC(FILT_CYC),
      .RST_BIT (RST_VAL[gi])
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .async_i(async_sig_i[gi]),
      .sync_o (sync_sig_o[gi]),
      .rise_o (rise_o[gi]),
      .fall_o (fall_o[gi])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - filtered and bypass builds against a window-based reference model
module tb_sync_debounce_bank;

  localparam int         STG  = 2;
  localparam int         FILT = 3;
  localparam logic [3:0] RSTV = 4'b1000;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] a_f  = 4'hF;
  logic [3:0] a_b  = 4'hF;
  logic [3:0] s_f, r_f, f_f;
  logic [3:0] s_b, r_b, f_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_debounce_bank #(.CH(4), .STAGES(STG), .FILT_CYC(FILT), .RST_VAL(RSTV)) dut_f (
    .clk(clk), .rstn(rstn), .async_sig_i(a_f), .sync_sig_o(s_f), .rise_o(r_f), .fall_o(f_f)
  );

  sync_debounce_bank #(.CH(4), .STAGES(STG), .FILT_CYC(0), .RST_VAL(RSTV)) dut_b (
    .clk(clk), .rstn(rstn), .async_sig_i(a_b), .sync_sig_o(s_b), .rise_o(r_b), .fall_o(f_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a level is adopted once the synchronised value has sat
  // opposite the output for the last FILT edges since reset (bypass: one edge).
  bit         inq[8][$];
  bit         rawq[8][$];
  logic [3:0] m_out[2];
  logic [3:0] m_rise[2];
  logic [3:0] m_fall[2];
  logic [3:0] rst_pat;

  task automatic model_reset();
    rst_pat = RSTV;
    for (int d = 0; d < 2; d++) begin
      m_out[d]  = rst_pat;
      m_rise[d] = '0;
      m_fall[d] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      inq[k].delete();
      rawq[k].delete();
    end
  endtask

  task automatic model_edge(input int d, input int f, input logic [3:0] x);
    for (int c = 0; c < 4; c++) begin
      int k;
      bit raw, old, nxt, all;
      k   = d * 4 + c;
      raw = (inq[k].size() >= STG) ? inq[k][inq[k].size() - STG] : rst_pat[c];
      inq[k].push_back(x[c]);
      if (inq[k].size() > 16) void'(inq[k].pop_front());
      rawq[k].push_back(raw);
      if (rawq[k].size() > 16) void'(rawq[k].pop_front());
      old = m_out[d][c];
      nxt = old;
      if (f == 0) begin
        nxt = raw;
      end else if (rawq[k].size() >= f) begin
        all = 1'b1;
        for (int j = 1; j <= f; j++) if (rawq[k][rawq[k].size() - j] == old) all = 1'b0;
        if (all) nxt = ~old;
      end
      m_rise[d][c] = nxt & ~old;
      m_fall[d][c] = ~nxt & old;
      m_out[d][c]  = nxt;
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else begin
      model_edge(0, FILT, a_f);
      model_edge(1, 0, a_b);
    end
  end

  always @(negedge clk) begin
    check("sync_f", s_f, m_out[0]);
    check("rise_f", r_f, m_rise[0]);
    check("fall_f", f_f, m_fall[0]);
    check("excl_f", r_f & f_f, 0);
    check("sync_b", s_b, m_out[1]);
    check("rise_b", r_b, m_rise[1]);
    check("fall_b", f_b, m_fall[1]);
    check("excl_b", r_b & f_b, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] acc;
    int rises, falls;

    // Reset with all inputs high
    repeat (3) tick();
    check("rst_sync", s_f, 4'b1000);
    check("rst_pulse", {r_f, f_f}, 0);
    check("rst_sync_b", s_b, 4'b1000);
    a_f  = 4'b1000;
    a_b  = 4'b1000;
    rstn = 1'b1;
    tick();
    check("rel_sync", s_f, 4'b1000);
    check("rel_pulse", {r_f, f_f}, 0);
    repeat (3) tick();

    // ch0 clean step: adopt at edge 5
    a_f[0] = 1'b1;
    repeat (4) tick();
    check("step_e4", s_f[0], 0);
    tick();
    check("step_e5", s_f, 4'b1001);
    check("step_rise", r_f, 4'b0001);
    check("model_e5", m_out[0], 4'b1001);
    tick();
    check("step_rise_gone", r_f, 0);

    // ch1 two-cycle glitch is filtered out
    a_f[1] = 1'b1;
    tick();
    tick();
    a_f[1] = 1'b0;
    acc = '0;
    repeat (8) begin
      tick();
      acc |= r_f | f_f;
    end
    check("glitch_pulse", acc, 0);
    check("glitch_sync", s_f, 4'b1001);

    // ch2 rises while ch3 falls on the same edge
    a_f = 4'b0101;
    repeat (4) tick();
    check("pair_e4", s_f, 4'b1001);
    tick();
    check("pair_sync", s_f, 4'b0101);
    check("pair_rise", r_f, 4'b0100);
    check("pair_fall", f_f, 4'b1000);

    // Reset mid-qualification discards the partial count
    a_f = 4'b0100;
    repeat (6) tick();
    check("pre_mid", s_f, 4'b0100);
    a_f = 4'b0101;
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_sync", s_f, 4'b1000);
    check("mid_rst_pulse", {r_f, f_f}, 0);
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    check("post_rel_e4", s_f, 4'b1000);
    tick();
    check("post_rel_sync", s_f, 4'b0101);
    check("post_rel_rise", r_f, 4'b0101);
    check("post_rel_fall", f_f, 4'b1000);
    check("model_rel", m_rise[0], 4'b0101);

    // Random levels with occasional reset pulses
    repeat (600) begin
      if ($urandom_range(3) == 0) a_f[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(2) == 0) a_b[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(199) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
      tick();
    end

    // Bypass build: 3-edge latency, one pulse per toggle
    a_b = 4'b1000;
    repeat (5) tick();
    a_b[0] = 1'b1;
    repeat (2) tick();
    check("byp_e2", s_b[0], 0);
    tick();
    check("byp_e3", s_b[0], 1);
    check("byp_rise", r_b, 4'b0001);
    repeat (5) tick();
    rises = 0;
    falls = 0;
    for (int t = 0; t < 6; t++) begin
      a_b[0] = ~a_b[0];
      repeat (8) begin
        tick();
        rises += int'(r_b[0]);
        falls += int'(f_b[0]);
      end
    end
    check("byp_rises", rises, 3);
    check("byp_falls", falls, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
